// File: rtl/riscv_decode_stage_if.sv
// rtl/riscv_decode_stage_if.sv - fetch-side and register-read-side handshake bundle of the decode stage
interface riscv_decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  branch;
  logic                  alu_src_imm;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       imm;
  logic                  illegal;
  logic [CNT_W-1:0]      illegal_cnt;

  modport master (
    output flush, in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_control, reg_write, mem_read, mem_write, branch,
           alu_src_imm, rd, rs1, rs2, funct3, imm, illegal, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, instr, out_ready,
    output in_ready, out_valid, alu_control, reg_write, mem_read, mem_write, branch,
           alu_src_imm, rd, rs1, rs2, funct3, imm, illegal, illegal_cnt
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - registered RV32I decode stage for R, I-ALU, LOAD, STORE and BRANCH
module riscv_decode_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                rst_n,
  riscv_decode_stage_if.slave io
);

  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b0110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src_imm;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
  } dec_t;

  // alt selects SUB for funct3=0 and SRA for funct3=5
  function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_base = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_base = ALU_SLL;
      3'd2:    alu_base = ALU_SLT;
      3'd3:    alu_base = ALU_SLTU;
      3'd4:    alu_base = ALU_XOR;
      3'd5:    alu_base = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic        legal;
  logic [3:0]  alu_code;
  logic [31:0] imm32;
  dec_t        dec;

  assign opcode = io.instr[6:0];
  assign f3     = io.instr[14:12];
  assign f7     = io.instr[31:25];
  assign i_imm  = {{20{io.instr[31]}}, io.instr[31:20]};
  assign s_imm  = {{20{io.instr[31]}}, io.instr[31:25], io.instr[11:7]};
  assign b_imm  = {{19{io.instr[31]}}, io.instr[31], io.instr[7], io.instr[30:25],
                   io.instr[11:8], 1'b0};

  always_comb begin
    legal    = 1'b0;
    alu_code = 4'b0000;
    imm32    = 32'd0;
    dec      = '0;
    dec.rd     = io.instr[11:7];
    dec.rs1    = io.instr[19:15];
    dec.rs2    = io.instr[24:20];
    dec.funct3 = f3;
    case (opcode)
      OP_R: begin
        legal         = (f7 == 7'd0) || ((f7 == 7'd32) && ((f3 == 3'd0) || (f3 == 3'd5)));
        alu_code      = alu_base(f3, f7[5]);
        dec.reg_write = 1'b1;
      end
      OP_I_ALU: begin
        if (f3 == 3'd1)      legal = (f7 == 7'd0);
        else if (f3 == 3'd5) legal = (f7 == 7'd0) || (f7 == 7'd32);
        else                 legal = 1'b1;
        alu_code        = alu_base(f3, (f3 == 3'd5) && f7[5]);
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm32           = i_imm;
      end
      OP_LOAD: begin
        legal           = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        alu_code        = ALU_ADD;
        dec.reg_write   = 1'b1;
        dec.mem_read    = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm32           = i_imm;
      end
      OP_STORE: begin
        legal           = (f3 <= 3'd2);
        alu_code        = ALU_ADD;
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm32           = s_imm;
      end
      OP_BRANCH: begin
        legal      = (f3 != 3'd2) && (f3 != 3'd3);
        alu_code   = (f3[2:1] == 2'b00) ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
        dec.branch = 1'b1;
        imm32      = b_imm;
      end
      default: legal = 1'b0;
    endcase
    dec.alu_control = ALU_CTRL_W'(alu_code);
    dec.imm         = XLEN'($signed(imm32));
    // Illegal words keep only the raw register/funct3 pass-through fields
    if (!legal) begin
      dec.alu_control = '0;
      dec.reg_write   = 1'b0;
      dec.mem_read    = 1'b0;
      dec.mem_write   = 1'b0;
      dec.branch      = 1'b0;
      dec.alu_src_imm = 1'b0;
      dec.imm         = '0;
      dec.illegal     = 1'b1;
    end
  end

  logic             out_valid_q, out_valid_d;
  dec_t             fields_q, fields_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             in_ready;
  logic             accept;

  assign in_ready = !io.flush && (!out_valid_q || io.out_ready);
  assign accept   = io.in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    fields_d      = fields_q;
    illegal_cnt_d = illegal_cnt_q;
    if (io.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      fields_d    = dec;
      if (dec.illegal && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end else if (io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      fields_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      fields_q      <= fields_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = out_valid_q;
  assign io.alu_control = fields_q.alu_control;
  assign io.reg_write   = fields_q.reg_write;
  assign io.mem_read    = fields_q.mem_read;
  assign io.mem_write   = fields_q.mem_write;
  assign io.branch      = fields_q.branch;
  assign io.alu_src_imm = fields_q.alu_src_imm;
  assign io.rd          = fields_q.rd;
  assign io.rs1         = fields_q.rs1;
  assign io.rs2         = fields_q.rs2;
  assign io.funct3      = fields_q.funct3;
  assign io.imm         = fields_q.imm;
  assign io.illegal     = fields_q.illegal;
  assign io.illegal_cnt = illegal_cnt_q;

endmodule
